// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Reads a multiplexed, active-low 7-segment display bus and turns it back
// into hex nibbles. It is the reader-side partner of the hex-to-7-segment
// driver. Both the bus and the digit selects are synchronised into the clock
// domain. A pattern must be held for STABLE_CYCLES identical samples before
// it is decoded and written into the digit it selects. When every digit has
// been refreshed, the block pulses frame_strobe for one cycle.
//
// Ports:
//   clk          : single clock; all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   seg_n        : segment lines, active-low, bit0=a .. bit6=g (asynchronous)
//   dig_sel      : digit enables, active-high, expected one-hot (asynchronous)
//   clr          : synchronous clear of captured digits and error flag
//   value        : decoded nibbles; digit i occupies bits [4i+3:4i]
//   digit_valid  : digit i holds a legal non-blank nibble
//   digit_blank  : last accepted pattern for digit i was blank
//   frame_strobe : one-cycle pulse after every digit has been accepted
//   pat_err      : sticky flag for illegal patterns or bad digit selects
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_sel,
   input  logic                    clr,
   output logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   digit_blank,
   output logic                    frame_strobe,
   output logic                    pat_err
);

   localparam int VW = 7 + NUM_DIGITS;
   localparam logic [VW-1:0] IDLE_VEC = {7'h7F, {NUM_DIGITS{1'b0}}};
   localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_SETTLE,
      ST_ACCEPT,
      ST_HELD
   } state_t;

   state_t state, state_next;
   logic [7:0] cnt, cnt_next;

   logic [6:0]            seg_s1, seg_s2;
   logic [NUM_DIGITS-1:0] sel_s1, sel_s2;
   logic [VW-1:0]         cur_vec, prev_vec, held_vec;
   logic [NUM_DIGITS-1:0] captured, cap_set;

   logic [6:0]            acc_seg;
   logic [NUM_DIGITS-1:0] acc_sel;
   logic [4:0]            dec;
   logic                  accepting, sel_ok, is_blank, is_idle;
   logic                  wr_digit, wr_blank, set_err, frame_done;

   // Returns {legal, nibble} for the canonical active-low hex glyphs.
   // Blank and all other patterns return legal=0.
   function automatic logic [4:0] decode_seg(input logic [6:0] s);
      case (s)
         7'h40:   decode_seg = 5'h10;
         7'h79:   decode_seg = 5'h11;
         7'h24:   decode_seg = 5'h12;
         7'h30:   decode_seg = 5'h13;
         7'h19:   decode_seg = 5'h14;
         7'h12:   decode_seg = 5'h15;
         7'h02:   decode_seg = 5'h16;
         7'h78:   decode_seg = 5'h17;
         7'h00:   decode_seg = 5'h18;
         7'h10:   decode_seg = 5'h19;
         7'h08:   decode_seg = 5'h1A;
         7'h03:   decode_seg = 5'h1B;
         7'h46:   decode_seg = 5'h1C;
         7'h21:   decode_seg = 5'h1D;
         7'h06:   decode_seg = 5'h1E;
         7'h0E:   decode_seg = 5'h1F;
         default: decode_seg = 5'h00;
      endcase
   endfunction

   // Two-flop synchronisers for the asynchronous bus, plus one more register
   // that holds the previous synchronised sample for the stability compare.
   // After reset they sit at the idle bus, so a live pattern present at
   // reset release is seen as a change and gets decoded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1   <= 7'h7F;
         seg_s2   <= 7'h7F;
         sel_s1   <= '0;
         sel_s2   <= '0;
         prev_vec <= IDLE_VEC;
      end else begin
         seg_s1   <= seg_n;
         seg_s2   <= seg_s1;
         sel_s1   <= dig_sel;
         sel_s2   <= sel_s1;
         prev_vec <= cur_vec;
      end
   end

   assign cur_vec = {seg_s2, sel_s2};

   // FSM state and stability counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_WAIT;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state logic. While settling, cnt counts the consecutive identical
   // samples, including the first sample of the new pattern. HELD compares
   // against the accepted vector rather than the previous sample. This way a
   // change that lands during the ACCEPT cycle is still detected.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_WAIT: begin
            cnt_next = '0;
            if (cur_vec != prev_vec) begin
               cnt_next   = 8'd1;
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cur_vec != prev_vec) begin
               cnt_next = 8'd1;
            end else begin
               if (cnt != 8'hFF) cnt_next = cnt + 8'd1;
               if (cnt_next >= STABLE_LIM) state_next = ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            state_next = ST_HELD;
         end
         ST_HELD: begin
            if (cur_vec != held_vec) begin
               cnt_next   = 8'd1;
               state_next = ST_SETTLE;
            end
         end
         default: begin
            state_next = ST_WAIT;
            cnt_next   = '0;
         end
      endcase
      if (clr) begin
         state_next = ST_WAIT;
         cnt_next   = '0;
      end
   end

   // Accept-cycle decisions. The accepted pattern is taken from prev_vec,
   // which holds the sample that completed the stability run. An all-zero
   // select with a blank bus is the idle bus, so it raises no error.
   always_comb begin
      acc_seg    = prev_vec[VW-1:NUM_DIGITS];
      acc_sel    = prev_vec[NUM_DIGITS-1:0];
      dec        = decode_seg(acc_seg);
      accepting  = (state == ST_ACCEPT) && !clr;
      sel_ok     = ($countones(acc_sel) == 1);
      is_blank   = (acc_seg == 7'h7F);
      is_idle    = is_blank && (acc_sel == '0);
      wr_digit   = accepting && sel_ok && dec[4];
      wr_blank   = accepting && sel_ok && is_blank;
      set_err    = accepting && !is_idle && (!sel_ok || (!dec[4] && !is_blank));
      cap_set    = (wr_digit || wr_blank) ? (captured | acc_sel) : captured;
      frame_done = (wr_digit || wr_blank) && (&cap_set);
   end

   // Captured digits, decoded outputs and frame tracking. Re-accepting a
   // digit before the frame completes only overwrites it, because captured
   // is a set of flags and not a count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value        <= '0;
         digit_valid  <= '0;
         digit_blank  <= '0;
         captured     <= '0;
         frame_strobe <= 1'b0;
         pat_err      <= 1'b0;
         held_vec     <= IDLE_VEC;
      end else begin
         frame_strobe <= 1'b0;
         if (state == ST_ACCEPT) held_vec <= prev_vec;
         if (clr) begin
            value       <= '0;
            digit_valid <= '0;
            digit_blank <= '0;
            captured    <= '0;
            pat_err     <= 1'b0;
         end else begin
            if (wr_digit) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  if (acc_sel[i]) value[4*i +: 4] <= dec[3:0];
               end
               digit_valid <= digit_valid | acc_sel;
               digit_blank <= digit_blank & ~acc_sel;
            end
            if (wr_blank) begin
               digit_valid <= digit_valid & ~acc_sel;
               digit_blank <= digit_blank | acc_sel;
            end
            if (set_err) pat_err <= 1'b1;
            if (frame_done) begin
               captured     <= '0;
               frame_strobe <= 1'b1;
            end else begin
               captured <= cap_set;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder
// Self-checking bench for seg7_scan_decoder with NUM_DIGITS=4 and
// STABLE_CYCLES=4. When a frame-completing digit is driven, the bench
// pushes the expected {digit_valid, value} onto a queue. A monitor pops
// and compares that entry on every frame_strobe. The scenario tasks check
// the steady-state outputs inline.
module tb_seg7_scan_decoder;

   localparam int N = 4;
   localparam int S = 4;

   logic           clk;
   logic           rst_n;
   logic [6:0]     seg_n;
   logic [N-1:0]   dig_sel;
   logic           clr;
   logic [4*N-1:0] value;
   logic [N-1:0]   digit_valid;
   logic [N-1:0]   digit_blank;
   logic           frame_strobe;
   logic           pat_err;

   int total = 0;
   int bad = 0;
   int strobe_count = 0;
   logic [4+4*N-1:0] frame_q[$];

   seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .seg_n        (seg_n),
      .dig_sel      (dig_sel),
      .clr          (clr),
      .value        (value),
      .digit_valid  (digit_valid),
      .digit_blank  (digit_blank),
      .frame_strobe (frame_strobe),
      .pat_err      (pat_err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame monitor: each strobe must match the oldest expected frame
   always @(negedge clk) begin
      if (rst_n && frame_strobe) begin
         logic [4+4*N-1:0] exp_f;
         strobe_count++;
         total++;
         if (frame_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL frame_unexpected: got value=%h valid=%b required no strobe", value, digit_valid);
         end else begin
            exp_f = frame_q.pop_front();
            if ({digit_valid, value} !== exp_f) begin
               bad++;
               $display("[TB] FAIL frame_content: got %h required %h", {digit_valid, value}, exp_f);
            end
         end
      end
   end

   // Drives the bus starting at a falling edge and holds it for n cycles
   task automatic applyStimulus(input logic [6:0] s, input logic [N-1:0] d, input int n);
      seg_n   = s;
      dig_sel = d;
      repeat (n) @(negedge clk);
   endtask

   // Reset release with the bus idle: everything must stay quiet
   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; seg_n = 7'h7F; dig_sel = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      total++; if (value !== 16'h0) begin bad++; $display("[TB] FAIL reset_value: got %h required 0000", value); end
      total++; if (digit_valid !== 4'h0) begin bad++; $display("[TB] FAIL reset_valid: got %b required 0000", digit_valid); end
      total++; if (digit_blank !== 4'h0) begin bad++; $display("[TB] FAIL reset_blank: got %b required 0000", digit_blank); end
      total++; if (pat_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_pat_err: got %b required 0", pat_err); end
      total++; if (strobe_count !== 0) begin bad++; $display("[TB] FAIL reset_strobe: got %0d required 0", strobe_count); end
   endtask

   // Full frame 3,4,A,F. The strobe must appear exactly 7 falling edges
   // after digit 3 is driven: 2 sync + 4 stable + 1 accept.
   task automatic test_frame();
      int sc0;
      sc0 = strobe_count;
      applyStimulus(7'h30, 4'b0001, 10);
      applyStimulus(7'h19, 4'b0010, 10);
      applyStimulus(7'h08, 4'b0100, 10);
      frame_q.push_back({4'hF, 16'hFA43});
      applyStimulus(7'h0E, 4'b1000, 0);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         total++;
         if (frame_strobe !== (k == 7)) begin
            bad++;
            $display("[TB] FAIL frame_timing k=%0d: got %b required %b", k, frame_strobe, (k == 7));
         end
      end
      applyStimulus(7'h7F, 4'b0000, 10);
      total++; if (value !== 16'hFA43) begin bad++; $display("[TB] FAIL frame_value: got %h required fa43", value); end
      total++; if (digit_valid !== 4'hF) begin bad++; $display("[TB] FAIL frame_valid: got %b required 1111", digit_valid); end
      total++; if (strobe_count !== sc0 + 1) begin bad++; $display("[TB] FAIL frame_count: got %0d required %0d", strobe_count, sc0 + 1); end
   endtask

   // Pattern held for only STABLE_CYCLES-1 samples must be ignored
   task automatic test_glitch();
      applyStimulus(7'h12, 4'b0010, S - 1);
      applyStimulus(7'h7F, 4'b0000, 12);
      total++; if (value !== 16'hFA43) begin bad++; $display("[TB] FAIL glitch_value: got %h required fa43", value); end
      total++; if (pat_err !== 1'b0) begin bad++; $display("[TB] FAIL glitch_pat_err: got %b required 0", pat_err); end
      total++; if (digit_valid !== 4'hF) begin bad++; $display("[TB] FAIL glitch_valid: got %b required 1111", digit_valid); end
   endtask

   // Blank on digit 2 keeps the nibble but flips valid/blank
   task automatic test_blank();
      applyStimulus(7'h7F, 4'b0100, 10);
      total++; if (digit_blank !== 4'b0100) begin bad++; $display("[TB] FAIL blank_flag: got %b required 0100", digit_blank); end
      total++; if (digit_valid !== 4'b1011) begin bad++; $display("[TB] FAIL blank_valid: got %b required 1011", digit_valid); end
      total++; if (value !== 16'hFA43) begin bad++; $display("[TB] FAIL blank_value: got %h required fa43", value); end
   endtask

   // Back-to-back frame with digit 0 written twice and digit 2 already
   // captured as blank: still exactly one strobe
   task automatic test_back_to_back();
      int sc0;
      sc0 = strobe_count;
      applyStimulus(7'h40, 4'b0001, 10);
      applyStimulus(7'h02, 4'b0001, 10);
      applyStimulus(7'h24, 4'b0010, 10);
      applyStimulus(7'h79, 4'b0100, 10);
      frame_q.push_back({4'hF, 16'h9126});
      applyStimulus(7'h10, 4'b1000, 10);
      applyStimulus(7'h7F, 4'b0000, 10);
      total++; if (strobe_count !== sc0 + 1) begin bad++; $display("[TB] FAIL b2b_count: got %0d required %0d", strobe_count, sc0 + 1); end
      total++; if (value !== 16'h9126) begin bad++; $display("[TB] FAIL b2b_value: got %h required 9126", value); end
      total++; if (digit_blank !== 4'h0) begin bad++; $display("[TB] FAIL b2b_blank: got %b required 0000", digit_blank); end
      total++; if (digit_valid !== 4'hF) begin bad++; $display("[TB] FAIL b2b_valid: got %b required 1111", digit_valid); end
   endtask

   // Illegal pattern and non-one-hot select both set the sticky error
   task automatic test_illegal();
      applyStimulus(7'h55, 4'b0001, 10);
      total++; if (pat_err !== 1'b1) begin bad++; $display("[TB] FAIL illegal_err: got %b required 1", pat_err); end
      total++; if (value !== 16'h9126) begin bad++; $display("[TB] FAIL illegal_value: got %h required 9126", value); end
      applyStimulus(7'h40, 4'b0001, 10);
      total++; if (pat_err !== 1'b1) begin bad++; $display("[TB] FAIL illegal_sticky: got %b required 1", pat_err); end
      total++; if (value !== 16'h9120) begin bad++; $display("[TB] FAIL illegal_next_value: got %h required 9120", value); end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      total++; if ({pat_err, digit_valid, value} !== 21'h0) begin bad++; $display("[TB] FAIL clr_all: got %h required 0", {pat_err, digit_valid, value}); end
      applyStimulus(7'h40, 4'b0011, 10);
      total++; if (pat_err !== 1'b1) begin bad++; $display("[TB] FAIL multisel_err: got %b required 1", pat_err); end
      total++; if (value !== 16'h0) begin bad++; $display("[TB] FAIL multisel_value: got %h required 0000", value); end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // clr coinciding with the ACCEPT cycle discards the data
   task automatic test_clr_accept();
      applyStimulus(7'h30, 4'b0001, 10);
      total++; if (value !== 16'h0003) begin bad++; $display("[TB] FAIL pre_clr_value: got %h required 0003", value); end
      applyStimulus(7'h79, 4'b0010, 6);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      total++; if (value !== 16'h0) begin bad++; $display("[TB] FAIL clr_acc_value: got %h required 0000", value); end
      total++; if (digit_valid !== 4'h0) begin bad++; $display("[TB] FAIL clr_acc_valid: got %b required 0000", digit_valid); end
      repeat (10) @(negedge clk);
      total++; if (value !== 16'h0) begin bad++; $display("[TB] FAIL clr_acc_hold: got %h required 0000", value); end
   endtask

   // Asynchronous reset in the middle of a settle window
   task automatic test_reset_mid_settle();
      applyStimulus(7'h30, 4'b0001, 10);
      applyStimulus(7'h55, 4'b0010, 10);
      total++; if ({pat_err, value} !== 17'h10003) begin bad++; $display("[TB] FAIL pre_rst_state: got %h required 10003", {pat_err, value}); end
      applyStimulus(7'h21, 4'b0100, 3);
      #1 rst_n = 1'b0;
      #1;
      total++; if (value !== 16'h0) begin bad++; $display("[TB] FAIL async_rst_value: got %h required 0000", value); end
      total++; if (digit_valid !== 4'h0) begin bad++; $display("[TB] FAIL async_rst_valid: got %b required 0000", digit_valid); end
      total++; if (pat_err !== 1'b0) begin bad++; $display("[TB] FAIL async_rst_err: got %b required 0", pat_err); end
      total++; if (frame_strobe !== 1'b0) begin bad++; $display("[TB] FAIL async_rst_strobe: got %b required 0", frame_strobe); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      total++; if (value !== 16'h0D00) begin bad++; $display("[TB] FAIL post_rst_value: got %h required 0d00", value); end
      total++; if (digit_valid !== 4'b0100) begin bad++; $display("[TB] FAIL post_rst_valid: got %b required 0100", digit_valid); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_glitch();
      test_blank();
      test_back_to_back();
      test_illegal();
      test_clr_accept();
      test_reset_mid_settle();
      total++;
      if (frame_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL frame_queue_drain: got %0d pending required 0", frame_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reader-side counterpart of the team's hex-to-7-segment display driver.
- Samples a multiplexed, active-low 7-segment bus plus one-hot digit selects, waits for the bus to settle, and decodes each segment pattern back to a hex nibble.
- Assembles nibbles into a multi-digit word and strobes it once every digit has been refreshed.
- Used in the ALU test harness to read back displayed results, and as a loopback checker on the display path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples needed before a pattern is accepted (2..255).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_n  input  7  segment lines, active-low: bit0=a, bit1=b … bit6=g. Asynchronous to clk.
- dig_sel  input  NUM_DIGITS  digit enables, active-high, expected one-hot. Asynchronous to clk.
- clr  input  1  synchronous clear of captured state and error flags.
- value  output  4*NUM_DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i = 1 while digit i holds a legal non-blank nibble.
- digit_blank  output  NUM_DIGITS  bit i = 1 if the last accepted pattern for digit i was blank (0x7F).
- frame_strobe  output  1  one-cycle pulse when every digit has been accepted since the last strobe.
- pat_err  output  1  sticky flag: an illegal pattern, or zero/multiple digits, held stable.

Behaviour:
- Input synchronisation: seg_n and dig_sel each pass through 2 flops before any comparison. Input-to-decision latency = 2 + STABLE_CYCLES cycles.
- Canonical encoding, seg_n as hex with bit6..bit0 = g..a:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Blank = 7F. Any other value is illegal.
- State machine:
  - WAIT: stability counter cnt=0. Any change in the synchronised {seg, sel} vector reloads cnt=1 and goes to SETTLE.
  - SETTLE: if {seg, sel} equals the previous sample, cnt increments; when cnt reaches STABLE_CYCLES, go to ACCEPT. Any change returns cnt to 1 and stays in SETTLE.
  - ACCEPT (one cycle), for sel one-hot with index i:
    - Legal digit: write value[i], set digit_valid[i], clear digit_blank[i], set captured[i].
    - Blank: clear digit_valid[i], set digit_blank[i], set captured[i]; value[i] unchanged.
    - Illegal pattern: set pat_err; digit i unchanged.
    - sel zero or not one-hot: set pat_err; no digit written. Exception: sel all-zero together with seg=7F is an idle bus, accepted silently with no effect.
    - Then go to HELD.
  - HELD: no re-acceptance until {seg, sel} changes, then go to SETTLE with cnt=1.
- cnt saturates and never wraps.
- Frame assembly: when captured becomes all-ones in an ACCEPT cycle:
  - frame_strobe=1 in the following cycle.
  - captured clears in that same cycle.
  - A digit accepted again before the frame completes overwrites its value and does not double-count.
- clr: same cycle effect as reset on value, digit_valid, digit_blank, captured, pat_err and frame_strobe. The FSM goes to WAIT. Synchronisers are not cleared.
- clr has priority over a simultaneous ACCEPT; the accepted data is discarded.
- Reset (rst_n low, at any time, including mid-SETTLE):
  - value=0, digit_valid=0, digit_blank=0, frame_strobe=0, pat_err=0.
  - captured=0, cnt=0, FSM=WAIT.
  - Synchroniser flops reset to seg=7F, sel=0.
- A pattern held for fewer than STABLE_CYCLES samples is ignored (glitch rejection).

Test Plan:
- Reset release, then bus held at seg_n=7F, dig_sel=0 -> all outputs 0, no pat_err, no frame_strobe.
- NUM_DIGITS=4: drive digits 0..3 with 30, 19, 08, 0E, each held 10 cycles -> value=16'hFA43, digit_valid=4'hF, exactly one frame_strobe, 1 cycle after the digit-3 ACCEPT.
- Digit 1 pattern held only STABLE_CYCLES-1 samples, then changed -> value[7:4] unchanged, no capture.
- seg_n=7F on digit 2 -> digit_blank[2]=1, digit_valid[2]=0, value[11:8] retained.
- seg_n=55 (illegal) held on digit 0, or dig_sel=4'b0011 -> pat_err=1 and stays 1.
- clr asserted in the same cycle as an ACCEPT -> outputs cleared.
- rst_n pulsed low mid-SETTLE -> all outputs 0 immediately, asynchronously.
